data_memory_stall_controller: RTL
=================================

// Module: data_memory_stall_controller
// PURPOSE
//  Sequences the MEM stage around the data cache and drives the hit input of the MEM/WB pipeline register.
//  - Read miss: stalls the pipeline and refills one cache block from main memory, word by word.
//  - Store: stalls the pipeline and performs a single-word write-through to main memory.
//  - During any stall, MEM/WB captures a bubble, so WB never retires an instruction twice.
// PARAMETERS
//  BLOCK_WORDS    4   words per cache block; power of 2, >=2
//  ADDR_WIDTH     32  byte address width
//  COUNTER_WIDTH  16  width of the saturating read-miss counter
// PORTS
//  clock                   in   1                  rising-edge clock
//  reset                   in   1                  synchronous, active-high
//  mem_read                in   1                  EX/MEM control: load in MEM stage
//  mem_write               in   1                  EX/MEM control: store in MEM stage
//  address                 in   ADDR_WIDTH         EX/MEM ALU result (byte address)
//  write_data              in   32                 EX/MEM store data
//  cache_hit               in   1                  data cache tag match and valid, this cycle
//  main_memory_ready       in   1                  memory accepted write / returns read word this cycle
//  main_memory_read_data   in   32                 returned word
//  main_memory_request     out  1                  transaction active
//  main_memory_write       out  1                  1=write, 0=read
//  main_memory_address     out  ADDR_WIDTH         word-aligned address
//  main_memory_write_data  out  32                 store data
//  cache_fill_enable       out  1                  write cache_fill_data into the cache line
//  cache_fill_word_index   out  log2(BLOCK_WORDS)  word slot being filled
//  cache_fill_data         out  32                 = main_memory_read_data
//  cache_fill_done         out  1                  set tag/valid; one pulse with the last fill word
//  pipeline_stall          out  1                  freeze PC, IF/ID, ID/EX, EX/MEM
//  mem_wb_hit              out  1                  to MEM/WB hit: 1=capture stage, 0=capture bubble
//  read_miss_count         out  COUNTER_WIDTH      saturating read-miss count
// BEHAVIOUR
//  Reset
//  - state=IDLE; word_count=0; read_miss_count=0.
//  - All outputs 0 except mem_wb_hit=1.
//  States
//  - IDLE
//    - mem_write=1 -> WRITE. A store takes priority when mem_read is also 1.
//    - else mem_read=1 and cache_hit=0 -> REFILL; read_miss_count += 1, saturating.
//    - stall is combinational and asserts in the detect cycle.
//  - REFILL
//    - request=1, write=0.
//    - address = {address[ADDR_WIDTH-1:log2(BLOCK_WORDS)+2], word_count, 2'b00}.
//    - Each cycle with ready=1: fill_enable=1, fill_word_index=word_count, then word_count += 1.
//    - The last word also pulses fill_done, clears word_count, and goes to IDLE.
//    - The next IDLE cycle sees cache_hit=1 and proceeds.
//  - WRITE
//    - request=1, write=1, address word-aligned, data=write_data.
//    - ready=1 -> WDONE.
//    - A write hit also updates the cache through the normal path; this block does not touch fill ports.
//  - WDONE
//    - Lasts one cycle: stall=0, mem_wb_hit=1, so the store leaves MEM.
//    - mem_write is not sampled in this cycle, which prevents re-issuing the same store. Next state is IDLE.
//  Outputs
//  - pipeline_stall = (IDLE & (mem_write | (mem_read & !cache_hit))) | REFILL | WRITE.
//  - mem_wb_hit = !pipeline_stall.
//  Timing
//  - Refill stall = 1 detect cycle + cycles until BLOCK_WORDS ready pulses.
//  - Store stall = 1 detect cycle + cycles to ready; then 1 WDONE cycle.
//  Boundary cases
//  - ready while idle/WDONE: ignored.
//  - Address or control inputs are held by the stalled EX/MEM; they are not re-latched mid-transaction.
//  - Counter sticks at 2^COUNTER_WIDTH-1.
//  - Reset mid-REFILL/WRITE: request drops at that edge, the partial line is left invalid (no fill_done), and in-flight data is ignored.
// STRUCTURE
//  - Shared include file holds:
//    - state encodings IDLE=2'd0, REFILL=2'd1, WRITE=2'd2, WDONE=2'd3
//    - the WORD_OFFSET_BITS=2 constant
//  - Sub-module: saturating_counter (WIDTH, increment, reset), used for read_miss_count.
//  - Remaining logic is one FSM plus word_count.
// TESTING
//  - Load hit: mem_read=1, cache_hit=1 -> stall=0, mem_wb_hit=1 every cycle, no request.
//  - Read miss at 0x00000104, BLOCK_WORDS=4, ready every cycle.
//    - Addresses are 0x100, 0x104, 0x108, 0x10C.
//    - fill_done with index 3; stall 5 cycles; count=1.
//  - Store to 0x20, data 111, ready after 3 cycles.
//    - write=1, stall held until ready, then one WDONE cycle with stall=0.
//    - Exactly one write request issued.
//  - mem_read=1 and mem_write=1 with cache_hit=0 -> WRITE path taken; read_miss_count unchanged.
//  - Reset after 2 of 4 refill words -> next cycle request=0, stall=0, word_count=0, no fill_done.
//  - COUNTER_WIDTH=2, 5 read misses -> read_miss_count=3.

Source files
------------

// File: rtl/data_memory_stall_controller_pkg.sv
// Shared definitions for the MEM-stage data-cache stall controller:
// controller state encodings and the byte-offset width within a word.
package data_memory_stall_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WRITE  = 2'd2,
      ST_WDONE  = 2'd3
   } state_e;

   localparam int WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/data_memory_stall_controller_saturating_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Once it reaches all-ones, the count holds there.
module saturating_counter
   import data_memory_stall_controller_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             increment_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (increment_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/data_memory_stall_controller.sv
// Sequences the MEM stage around the data cache.
// A read miss refills one block word by word; a store does a single-word write-through.
module data_memory_stall_controller
   import data_memory_stall_controller_pkg::*;
#(
   parameter int BLOCK_WORDS   = 4,
   parameter int ADDR_WIDTH    = 32,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           mem_read,
   input  logic                           mem_write,
   input  logic [ADDR_WIDTH-1:0]          address,
   input  logic [31:0]                    write_data,
   input  logic                           cache_hit,
   input  logic                           main_memory_ready,
   input  logic [31:0]                    main_memory_read_data,
   output logic                           main_memory_request,
   output logic                           main_memory_write,
   output logic [ADDR_WIDTH-1:0]          main_memory_address,
   output logic [31:0]                    main_memory_write_data,
   output logic                           cache_fill_enable,
   output logic [$clog2(BLOCK_WORDS)-1:0] cache_fill_word_index,
   output logic [31:0]                    cache_fill_data,
   output logic                           cache_fill_done,
   output logic                           pipeline_stall,
   output logic                           mem_wb_hit,
   output logic [COUNTER_WIDTH-1:0]       read_miss_count
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] word_count_q;
   logic [IDX_W-1:0] word_count_d;
   logic             read_miss_s;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      word_count_d           = word_count_q;
      read_miss_s            = 1'b0;
      main_memory_request    = 1'b0;
      main_memory_write      = 1'b0;
      main_memory_address    = '0;
      main_memory_write_data = 32'd0;
      cache_fill_enable      = 1'b0;
      cache_fill_word_index  = '0;
      cache_fill_data        = 32'd0;
      cache_fill_done        = 1'b0;
      pipeline_stall         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A store wins over a simultaneous load so the load is never counted as a miss.
            if (mem_write) begin
               pipeline_stall = 1'b1;
               state_d        = ST_WRITE;
            end else if (mem_read && !cache_hit) begin
               pipeline_stall = 1'b1;
               read_miss_s    = 1'b1;
               state_d        = ST_REFILL;
            end else begin
               state_d        = ST_IDLE;
            end
         end
         ST_REFILL: begin
            pipeline_stall      = 1'b1;
            main_memory_request = 1'b1;
            main_memory_address = {address[ADDR_WIDTH-1:IDX_W+WORD_OFFSET_BITS], word_count_q,
                                   {WORD_OFFSET_BITS{1'b0}}};
            if (main_memory_ready) begin
               cache_fill_enable     = 1'b1;
               cache_fill_word_index = word_count_q;
               cache_fill_data       = main_memory_read_data;
               if (word_count_q == IDX_W'(BLOCK_WORDS - 1)) begin
                  cache_fill_done = 1'b1;
                  word_count_d    = '0;
                  state_d         = ST_IDLE;
               end else begin
                  word_count_d    = word_count_q + IDX_W'(1);
               end
            end else begin
               word_count_d = word_count_q;
            end
         end
         ST_WRITE: begin
            pipeline_stall         = 1'b1;
            main_memory_request    = 1'b1;
            main_memory_write      = 1'b1;
            main_memory_address    = {address[ADDR_WIDTH-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
            main_memory_write_data = write_data;
            if (main_memory_ready) begin
               state_d = ST_WDONE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WDONE: begin
            // mem_write is deliberately ignored here; the store is still in EX/MEM this cycle.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_wb_hit = ~pipeline_stall;

   saturating_counter #(
      .WIDTH(COUNTER_WIDTH)
   ) u_read_miss_counter (
      .clock_i    (clock),
      .reset_i    (reset),
      .increment_i(read_miss_s),
      .count_o    (read_miss_count)
   );

endmodule
